disp_mux_scan: RTL

- Parametrised seven-segment scan multiplexer driving NUM_DIGITS common-anode digits from one shared segment bus.
- Adds a programmable per-digit refresh period, anti-ghosting blank time between digits, a per-digit enable mask, registered glitch-free outputs and a frame strobe.
- Sits between the display-formatting logic (hex/BCD-to-segment encoders) and the board pins.

---
 rtl/disp_mux_scan_if.sv | 35 +++
 rtl/disp_mux_scan.sv | 96 +++++++++
 2 files changed

// File: rtl/disp_mux_scan_if.sv
// rtl/disp_mux_scan_if.sv - segment/anode bus for disp_mux_scan; adds bright when DISP_MUX_SCAN_PWM_EN is defined
interface disp_mux_scan_if #(
   parameter int NUM_DIGITS = 4
);
   logic [8*NUM_DIGITS-1:0] in;
   logic [NUM_DIGITS-1:0]   dig_en;
`ifdef DISP_MUX_SCAN_PWM_EN
   logic [3:0]              bright;
`endif
   logic [NUM_DIGITS-1:0]   an;
   logic [7:0]              sseg;
   logic                    frame_tick;

   modport master (
      output in,
      output dig_en,
`ifdef DISP_MUX_SCAN_PWM_EN
      output bright,
`endif
      input  an,
      input  sseg,
      input  frame_tick
   );

   modport slave (
      input  in,
      input  dig_en,
`ifdef DISP_MUX_SCAN_PWM_EN
      input  bright,
`endif
      output an,
      output sseg,
      output frame_tick
   );
endinterface

// File: rtl/disp_mux_scan.sv
// rtl/disp_mux_scan.sv - seven-segment scan multiplexer with blank time, digit mask and frame strobe
// Optional anode PWM dimming under DISP_MUX_SCAN_PWM_EN.
module disp_mux_scan #(
   parameter int NUM_DIGITS = 4,
   parameter int TICK_DIV   = 50000,
   parameter int BLANK_CYC  = 16
) (
   input  logic            clk,
   input  logic            reset,
   disp_mux_scan_if.slave  bus
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0]         CNT_LAST   = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYC - 1);
   localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] ONE_HOT0   = NUM_DIGITS'(1);

   typedef enum logic {BLANK, DRIVE} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [7:0]              sseg_q, sseg_d;
   logic                    frame_q, frame_d;
   logic                    pwm_on;

`ifdef DISP_MUX_SCAN_PWM_EN
   logic [3:0]              pwm_q, pwm_d;

   assign pwm_d  = pwm_q + 4'd1;
   assign pwm_on = (pwm_q <= bus.bright);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) pwm_q <= 4'd0;
      else       pwm_q <= pwm_d;
   end
`else
   assign pwm_on = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= BLANK;
         cnt_q   <= '0;
         idx_q   <= '0;
         an_q    <= '1;
         sseg_q  <= 8'hFF;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         sseg_q  <= sseg_d;
         frame_q <= frame_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      idx_d   = idx_q;
      case (state_q)
         BLANK: begin
            if (cnt_q == BLANK_LAST) state_d = DRIVE;
         end
         DRIVE: begin
            if (cnt_q == CNT_LAST) begin
               state_d = BLANK;
               cnt_d   = '0;
               idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            end
         end
         default: state_d = BLANK;
      endcase
   end

   // Outputs are computed from the next state so the pins change on the same edge as the FSM.
   always_comb begin
      sseg_d  = sseg_q;
      an_d    = '1;
      frame_d = (state_q == DRIVE) && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
      if (state_q == BLANK && cnt_q == BLANK_LAST)
         sseg_d = bus.in[{idx_q, 3'b000} +: 8];
      if (state_d == BLANK)
         sseg_d = 8'hFF;
      else if (bus.dig_en[idx_q] && pwm_on)
         an_d = ~(ONE_HOT0 << idx_q);
   end

   assign bus.an         = an_q;
   assign bus.sseg       = sseg_q;
   assign bus.frame_tick = frame_q;
endmodule
